// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//   MEM-stage data-memory access sequencer. Takes the load/store controls held
//   in EX/MEM, runs a req/gnt/rvalid handshake with the data-memory port,
//   formats store strobes/data, extends load data, stalls the pipeline while
//   an access is in flight, and flags misaligned accesses instead of issuing.
//
// Ports
//   i_clk, i_rst         clock, asynchronous active-high reset
//   i_dm_rd, i_dm_wr     load / store request from EX/MEM
//   i_aluout             byte address
//   i_dm_data            right-aligned store data
//   i_datatype           funct3 access type (B/H/W/BU/HU, others = W)
//   i_flush              kill the EX/MEM instruction (sampled in IDLE only)
//   o_mem_req/o_mem_we   bus request / write enable
//   o_mem_addr           word-aligned bus address
//   o_mem_wstrb          byte strobes (0 for loads)
//   o_mem_wdata          lane-replicated store data
//   i_mem_gnt            bus accepted the request
//   i_mem_rvalid         read data valid
//   i_mem_rdata          read data
//   o_mem_stall          freeze IF..EX/MEM
//   o_ld_data/o_ld_valid extended load result / valid in DONE
//   o_misalign           one-cycle misaligned-access flag
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 32,
    parameter int TYPE_BITS = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_dm_rd,
    input  logic                 i_dm_wr,
    input  logic [ADDR_BITS-1:0] i_aluout,
    input  logic [DATA_BITS-1:0] i_dm_data,
    input  logic [TYPE_BITS-1:0] i_datatype,
    input  logic                 i_flush,
    output logic                 o_mem_req,
    output logic                 o_mem_we,
    output logic [ADDR_BITS-1:0] o_mem_addr,
    output logic [3:0]           o_mem_wstrb,
    output logic [DATA_BITS-1:0] o_mem_wdata,
    input  logic                 i_mem_gnt,
    input  logic                 i_mem_rvalid,
    input  logic [DATA_BITS-1:0] i_mem_rdata,
    output logic                 o_mem_stall,
    output logic [DATA_BITS-1:0] o_ld_data,
    output logic                 o_ld_valid,
    output logic                 o_misalign
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Access size from funct3; unknown codes behave as a word access.
    function automatic logic [1:0] f_size(input logic [TYPE_BITS-1:0] t);
        logic [1:0] sz;
        case (t)
            TYPE_BITS'(3'b000), TYPE_BITS'(3'b100): sz = SZ_BYTE;
            TYPE_BITS'(3'b001), TYPE_BITS'(3'b101): sz = SZ_HALF;
            default:                                sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic f_unsigned(input logic [TYPE_BITS-1:0] t);
        return (t == TYPE_BITS'(3'b100)) || (t == TYPE_BITS'(3'b101));
    endfunction

    function automatic logic f_misaligned(input logic [1:0] sz, input logic [1:0] off);
        logic mis;
        case (sz)
            SZ_WORD: mis = (off != 2'b00);
            SZ_HALF: mis = off[0];
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    state_t                 r_state;
    state_t                 w_next_state;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [1:0]             r_off;
    logic [TYPE_BITS-1:0]   r_type;
    logic                   r_we;
    logic [3:0]             r_wstrb;
    logic [DATA_BITS-1:0]   r_wdata;
    logic [DATA_BITS-1:0]   r_ld_data;

    logic                   w_pending;
    logic [1:0]             w_in_size;
    logic                   w_misaligned;
    logic                   w_latch;
    logic [3:0]             w_fmt_wstrb;
    logic [DATA_BITS-1:0]   w_fmt_wdata;
    logic [7:0]             w_ld_byte;
    logic [15:0]            w_ld_half;
    logic [DATA_BITS-1:0]   w_ld_ext;

    assign w_pending    = (i_dm_rd | i_dm_wr) & ~i_flush;
    assign w_in_size    = f_size(i_datatype);
    assign w_misaligned = f_misaligned(w_in_size, i_aluout[1:0]);

    // Store formatting: strobes shifted to the addressed lanes, data replicated.
    always_comb begin
        w_fmt_wstrb = 4'hF;
        w_fmt_wdata = i_dm_data;
        case (w_in_size)
            SZ_BYTE: begin
                w_fmt_wstrb = 4'b0001 << i_aluout[1:0];
                w_fmt_wdata = {(DATA_BITS/8){i_dm_data[7:0]}};
            end
            SZ_HALF: begin
                w_fmt_wstrb = 4'b0011 << i_aluout[1:0];
                w_fmt_wdata = {(DATA_BITS/16){i_dm_data[15:0]}};
            end
            default: begin
                w_fmt_wstrb = 4'hF;
                w_fmt_wdata = i_dm_data;
            end
        endcase
    end

    // Load extraction uses the latched offset/type, not the live EX/MEM inputs.
    assign w_ld_byte = i_mem_rdata[{r_off, 3'b000} +: 8];
    assign w_ld_half = i_mem_rdata[{r_off[1], 4'b0000} +: 16];

    // Sign/zero extension of the selected load lane.
    always_comb begin
        w_ld_ext = i_mem_rdata;
        case (f_size(r_type))
            SZ_BYTE: begin
                if (f_unsigned(r_type)) begin
                    w_ld_ext = {{(DATA_BITS-8){1'b0}}, w_ld_byte};
                end else begin
                    w_ld_ext = {{(DATA_BITS-8){w_ld_byte[7]}}, w_ld_byte};
                end
            end
            SZ_HALF: begin
                if (f_unsigned(r_type)) begin
                    w_ld_ext = {{(DATA_BITS-16){1'b0}}, w_ld_half};
                end else begin
                    w_ld_ext = {{(DATA_BITS-16){w_ld_half[15]}}, w_ld_half};
                end
            end
            default: w_ld_ext = i_mem_rdata;
        endcase
    end

    // Next-state logic; flush and misalignment only matter in IDLE.
    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pending && !w_misaligned) begin
                    w_next_state = ST_REQ;
                    w_latch      = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (i_mem_gnt) begin
                    w_next_state = r_we ? ST_DONE : ST_WAIT;
                end else begin
                    w_next_state = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (i_mem_rvalid) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture the accepted access so bus outputs stay stable through REQ.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr  <= {ADDR_BITS{1'b0}};
            r_off   <= 2'b00;
            r_type  <= {TYPE_BITS{1'b0}};
            r_we    <= 1'b0;
            r_wstrb <= 4'b0000;
            r_wdata <= {DATA_BITS{1'b0}};
        end else if (w_latch) begin
            r_addr  <= {i_aluout[ADDR_BITS-1:2], 2'b00};
            r_off   <= i_aluout[1:0];
            r_type  <= i_datatype;
            r_we    <= i_dm_wr;
            r_wstrb <= i_dm_wr ? w_fmt_wstrb : 4'b0000;
            r_wdata <= w_fmt_wdata;
        end
    end

    // Load result register; only a response in WAIT updates it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ld_data <= {DATA_BITS{1'b0}};
        end else if ((r_state == ST_WAIT) && i_mem_rvalid) begin
            r_ld_data <= w_ld_ext;
        end
    end

    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_ld_data   = r_ld_data;

    // Output decode. IDLE outputs are gated by reset so that asserting reset
    // with a request still presented shows reset values at once.
    always_comb begin
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_wstrb = 4'b0000;
        o_mem_stall = 1'b0;
        o_ld_valid  = 1'b0;
        o_misalign  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!i_rst && w_pending) begin
                    o_misalign  = w_misaligned;
                    o_mem_stall = ~w_misaligned;
                end else begin
                    o_misalign  = 1'b0;
                    o_mem_stall = 1'b0;
                end
            end
            ST_REQ: begin
                o_mem_req   = 1'b1;
                o_mem_we    = r_we;
                o_mem_wstrb = r_wstrb;
                o_mem_stall = 1'b1;
            end
            ST_WAIT: o_mem_stall = 1'b1;
            ST_DONE: o_ld_valid  = ~r_we;
            default: o_mem_stall = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        dm_rd, dm_wr, flush;
    logic [31:0] aluout, dm_data;
    logic [2:0]  datatype;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        o_mem_req, o_mem_we, o_mem_stall, o_ld_valid, o_misalign;
    logic [31:0] o_mem_addr, o_mem_wdata, o_ld_data;
    logic [3:0]  o_mem_wstrb;

    mem_access_ctrl #(.DATA_BITS(32), .ADDR_BITS(32), .TYPE_BITS(3)) dut (
        .i_clk(clk), .i_rst(rst), .i_dm_rd(dm_rd), .i_dm_wr(dm_wr),
        .i_aluout(aluout), .i_dm_data(dm_data), .i_datatype(datatype), .i_flush(flush),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wstrb(o_mem_wstrb), .o_mem_wdata(o_mem_wdata),
        .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
        .o_mem_stall(o_mem_stall), .o_ld_data(o_ld_data), .o_ld_valid(o_ld_valid),
        .o_misalign(o_misalign)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] K_REQ = 2'd0;
    localparam logic [1:0] K_LD  = 2'd1;
    localparam logic [1:0] K_MIS = 2'd2;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] ld;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          gnt_dly = 0;
    int          rv_after = 1;
    logic [31:0] rsp_rdata = 32'h0;
    bit          stray_rv = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_req(input logic [31:0] addr, input logic we, input logic [3:0] wstrb,
                            input logic [31:0] wdata);
        exp_t e;
        e.kind = K_REQ; e.addr = addr; e.we = we; e.wstrb = wstrb; e.wdata = wdata; e.ld = 32'h0;
        sb_q.push_back(e);
    endtask

    task automatic push_ld(input logic [31:0] val);
        exp_t e;
        e.kind = K_LD; e.addr = 32'h0; e.we = 1'b0; e.wstrb = 4'h0; e.wdata = 32'h0; e.ld = val;
        sb_q.push_back(e);
    endtask

    task automatic push_mis();
        exp_t e;
        e.kind = K_MIS; e.addr = 32'h0; e.we = 1'b0; e.wstrb = 4'h0; e.wdata = 32'h0; e.ld = 32'h0;
        sb_q.push_back(e);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    task automatic pop_check(input logic [1:0] kind);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_event: got kind %0d expected none", kind);
        end else begin
            e = sb_q.pop_front();
            chk("event_kind", {30'h0, kind}, {30'h0, e.kind});
            if (e.kind == kind) begin
                case (kind)
                    K_REQ: begin
                        chk("req_addr", o_mem_addr, e.addr);
                        chk("req_we", {31'h0, o_mem_we}, {31'h0, e.we});
                        chk("req_wstrb", {28'h0, o_mem_wstrb}, {28'h0, e.wstrb});
                        if (e.we) chk("req_wdata", o_mem_wdata, e.wdata);
                    end
                    K_LD:    chk("ld_data", o_ld_data, e.ld);
                    default: chk("misalign_stall", {31'h0, o_mem_stall}, 32'h0);
                endcase
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (o_mem_req && mem_gnt) pop_check(K_REQ);
            if (o_ld_valid) pop_check(K_LD);
            if (o_misalign) pop_check(K_MIS);
        end
    end

    // Bus responder: grant after gnt_dly REQ cycles, rvalid rv_after cycles after grant.
    initial begin
        int req_age;
        int rv_cnt;
        bit rv_pend;
        req_age = 0; rv_cnt = 0; rv_pend = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            if (rst) begin
                req_age = 0;
                rv_pend = 1'b0;
            end else if (o_mem_req) begin
                if (req_age >= gnt_dly) begin
                    mem_gnt = 1'b1;
                    req_age = 0;
                    rv_pend = !o_mem_we;
                    rv_cnt  = 1;
                end else begin
                    req_age++;
                end
            end else if (rv_pend) begin
                if (rv_cnt >= rv_after) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rsp_rdata;
                    rv_pend    = 1'b0;
                end else begin
                    rv_cnt++;
                end
            end else if (stray_rv) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hDEAD_0000;
            end
        end
    end

    // Present one access and measure its length; called at posedge+1.
    task automatic access(input logic rd, input logic wr, input logic [2:0] typ,
                          input logic [31:0] addr, input logic [31:0] data,
                          input int gdly, input int rvd, input logic [31:0] rdata,
                          input int exp_cycles, input int exp_req);
        int cyc;
        int req_cyc;
        bit done;
        logic [31:0] waddr;
        waddr = {addr[31:2], 2'b00};
        gnt_dly = gdly; rv_after = rvd; rsp_rdata = rdata;
        dm_rd = rd; dm_wr = wr; datatype = typ; aluout = addr; dm_data = data;
        cyc = 0; req_cyc = 0; done = 1'b0;
        while (!done && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (o_mem_req) begin
                req_cyc++;
                chk("req_addr_stable", o_mem_addr, waddr);
            end
            if (!o_mem_stall) done = 1'b1;
        end
        chk("access_cycles", cyc, exp_cycles);
        chk("req_cycles", req_cyc, exp_req);
        @(posedge clk); #1;
        dm_rd = 1'b0; dm_wr = 1'b0; flush = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_mem_req", {31'h0, o_mem_req}, 32'h0);
        chk("rst_mem_we", {31'h0, o_mem_we}, 32'h0);
        chk("rst_mem_addr", o_mem_addr, 32'h0);
        chk("rst_mem_wstrb", {28'h0, o_mem_wstrb}, 32'h0);
        chk("rst_mem_wdata", o_mem_wdata, 32'h0);
        chk("rst_mem_stall", {31'h0, o_mem_stall}, 32'h0);
        chk("rst_ld_data", o_ld_data, 32'h0);
        chk("rst_ld_valid", {31'h0, o_ld_valid}, 32'h0);
        chk("rst_misalign", {31'h0, o_misalign}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; dm_rd = 1'b0; dm_wr = 1'b0; flush = 1'b0;
        aluout = 32'h0; dm_data = 32'h0; datatype = 3'b010;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst = 1'b0;
        @(posedge clk); #1;

        // SB: byte lane 2, grant in first REQ cycle
        push_req(32'h0000_1000, 1'b1, 4'b0100, 32'hA5A5_A5A5);
        access(1'b0, 1'b1, 3'b000, 32'h0000_1002, 32'h0000_00A5, 0, 1, 32'h0, 3, 1);
        // LH / LHU: upper halfword, rvalid 2 cycles after grant
        push_req(32'h0000_2000, 1'b0, 4'b0000, 32'h0); push_ld(32'hFFFF_8001);
        access(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0, 0, 2, 32'h8001_1234, 5, 1);
        push_req(32'h0000_2000, 1'b0, 4'b0000, 32'h0); push_ld(32'h0000_8001);
        access(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0, 0, 2, 32'h8001_1234, 5, 1);
        // LB lane 3 with 3-cycle grant delay
        push_req(32'h0000_3000, 1'b0, 4'b0000, 32'h0); push_ld(32'h0000_007F);
        access(1'b1, 1'b0, 3'b000, 32'h0000_3003, 32'h0, 3, 1, 32'h7F00_0000, 7, 4);
        // LB lane 1 negative, LBU lane 2
        push_req(32'h0000_3000, 1'b0, 4'b0000, 32'h0); push_ld(32'hFFFF_FF80);
        access(1'b1, 1'b0, 3'b000, 32'h0000_3001, 32'h0, 0, 1, 32'h0000_8000, 4, 1);
        push_req(32'h0000_3000, 1'b0, 4'b0000, 32'h0); push_ld(32'h0000_00FF);
        access(1'b1, 1'b0, 3'b100, 32'h0000_3002, 32'h0, 0, 1, 32'h00FF_0000, 4, 1);
        // SH upper lanes, 1-cycle grant delay; SW; reserved type 011 as W
        push_req(32'h0000_1004, 1'b1, 4'b1100, 32'hBEEF_BEEF);
        access(1'b0, 1'b1, 3'b001, 32'h0000_1006, 32'h0000_BEEF, 1, 1, 32'h0, 4, 2);
        push_req(32'h0000_1008, 1'b1, 4'b1111, 32'h1234_5678);
        access(1'b0, 1'b1, 3'b010, 32'h0000_1008, 32'h1234_5678, 0, 1, 32'h0, 3, 1);
        push_req(32'h0000_100C, 1'b1, 4'b1111, 32'hDEAD_BEEF);
        access(1'b0, 1'b1, 3'b011, 32'h0000_100C, 32'hDEAD_BEEF, 0, 1, 32'h0, 3, 1);
        // LW and LH lower halfword positive
        push_req(32'h0000_200C, 1'b0, 4'b0000, 32'h0); push_ld(32'hCAFE_F00D);
        access(1'b1, 1'b0, 3'b010, 32'h0000_200C, 32'h0, 0, 1, 32'hCAFE_F00D, 4, 1);
        push_req(32'h0000_2000, 1'b0, 4'b0000, 32'h0); push_ld(32'h0000_7FFF);
        access(1'b1, 1'b0, 3'b001, 32'h0000_2000, 32'h0, 0, 1, 32'h1234_7FFF, 4, 1);

        // Misaligned accesses: one-cycle flag, no request, no stall
        push_mis();
        access(1'b1, 1'b0, 3'b010, 32'h0000_4001, 32'h0, 0, 1, 32'h0, 1, 0);
        push_mis();
        access(1'b0, 1'b1, 3'b001, 32'h0000_4003, 32'h0000_1111, 0, 1, 32'h0, 1, 0);
        push_mis();
        access(1'b0, 1'b1, 3'b010, 32'h0000_4002, 32'h2222_2222, 0, 1, 32'h0, 1, 0);

        // Flushed store: nothing issued
        flush = 1'b1;
        access(1'b0, 1'b1, 3'b010, 32'h0000_1010, 32'h3333_3333, 0, 1, 32'h0, 1, 0);

        // Stray rvalid in IDLE: no ld_valid, ld_data holds
        #2 stray_rv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_ld_valid", {31'h0, o_ld_valid}, 32'h0);
            chk("stray_ld_data", o_ld_data, 32'h0000_7FFF);
            if (i == 0) #3 stray_rv = 1'b0;
        end
        @(posedge clk); #1;

        // Reset while in WAIT
        gnt_dly = 0; rv_after = 6; rsp_rdata = 32'h1111_1111;
        push_req(32'h0000_5000, 1'b0, 4'b0000, 32'h0);
        dm_rd = 1'b1; datatype = 3'b010; aluout = 32'h0000_5000;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_req", {31'h0, o_mem_req}, 32'h1);
        @(negedge clk);
        chk("wait_stall", {31'h0, o_mem_stall}, 32'h1);
        chk("wait_req", {31'h0, o_mem_req}, 32'h0);
        #1 rst = 1'b1;
        #1;
        chk_reset_outputs();
        dm_rd = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_req", {31'h0, o_mem_req}, 32'h0);
            chk("post_rst_stall", {31'h0, o_mem_stall}, 32'h0);
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
